// File: rtl/mlblock_cfg_pkg.sv
// Shared types and sizing helpers for the MLBlock configuration-chain loader.
package mlblock_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } cfg_state_t;

    localparam int DEF_CHAIN_LEN = 16;
    localparam int DEF_WORD_W    = 8;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Width of a counter that indexes ceil(a/b) items; never narrower than 1 bit.
    function automatic int clog2_ceil_div(input int a, input int b);
        int n;
        n = ceil_div(a, b);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mlblock_cfg_serializer.sv
// Parallel-in serial-out stage driving the configuration chain head, MSB first.
// config_en and config_in share one register stage so they stay aligned.
module mlblock_cfg_serializer
    import mlblock_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:0] image,
    output logic                 config_en,
    output logic                 config_in,
    output logic                 last
);

    localparam int BCNT_W = clog2_ceil_div(CHAIN_LEN, 1);

    logic [CHAIN_LEN-1:0] shreg;
    logic [BCNT_W-1:0]    bcnt;

    // bcnt counts the bits still to follow the one currently on config_in
    assign last = config_en && (bcnt == '0);

    // Load presents the MSB immediately; each enabled cycle then advances one bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bcnt      <= '0;
            config_en <= 1'b0;
            config_in <= 1'b0;
        end else if (load) begin
            shreg     <= {image[CHAIN_LEN-2:0], 1'b0};
            bcnt      <= BCNT_W'(CHAIN_LEN - 1);
            config_en <= 1'b1;
            config_in <= image[CHAIN_LEN-1];
        end else if (config_en) begin
            if (bcnt == '0) begin
                config_en <= 1'b0;
                config_in <= 1'b0;
            end else begin
                config_in <= shreg[CHAIN_LEN-1];
                shreg     <= {shreg[CHAIN_LEN-2:0], 1'b0};
                bcnt      <= bcnt - BCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mlblock_cfg_loader.sv
// Writer end of the MLBlock serial configuration chain: collects an image as
// parallel words, then shifts it into the daisy-chained blocks.
// Optional readback of the previous chain contents: MLBLOCK_CFG_READBACK_EN.
module mlblock_cfg_loader
    import mlblock_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_W-1:0]    cfg_word,
    input  logic                 cfg_word_valid,
    output logic                 cfg_word_ready,
    output logic                 config_en,
    output logic                 config_in,
    input  logic                 config_out,
    output logic                 busy,
    output logic                 done
`ifdef MLBLOCK_CFG_READBACK_EN
    ,
    output logic [CHAIN_LEN-1:0] rb_image,
    output logic                 rb_valid
`endif
);

    // state   | meaning
    // IDLE    | waiting for start
    // COLLECT | accepting image words, ready held high
    // SHIFT   | config_en high, image streaming MSB first
    // DONE    | one-cycle done pulse, start ignored

    localparam int N_WORDS = ceil_div(CHAIN_LEN, WORD_W);
    localparam int WCNT_W  = clog2_ceil_div(CHAIN_LEN, WORD_W);

    cfg_state_t           state;
    logic [WCNT_W-1:0]    wcnt;
    logic [CHAIN_LEN-1:0] image;
    logic [CHAIN_LEN-1:0] image_nxt;
    logic                 hs;
    logic                 last_word;
    logic                 ser_load;
    logic                 ser_last;

    assign cfg_word_ready = (state == COLLECT);
    assign hs             = cfg_word_ready && cfg_word_valid;
    assign last_word      = (wcnt == WCNT_W'(N_WORDS - 1));
    // The serializer loads from image_nxt so shifting starts right after the final word.
    assign ser_load       = hs && last_word;

    // Word slot wcnt overlays its image bits; bits past CHAIN_LEN have no slot and drop out.
    for (genvar b = 0; b < CHAIN_LEN; b++) begin : g_bit
        assign image_nxt[b] = (wcnt == WCNT_W'(b / WORD_W)) ? cfg_word[b % WORD_W] : image[b];
    end

    // Word collector: store each accepted word and advance the slot counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt  <= '0;
            image <= '0;
        end else if (hs) begin
            image <= image_nxt;
            wcnt  <= last_word ? '0 : wcnt + WCNT_W'(1);
        end
    end

    // Sequencing FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (ser_load) state <= SHIFT;
                end
                SHIFT: begin
                    if (ser_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    mlblock_cfg_serializer #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .image     (image_nxt),
        .config_en (config_en),
        .config_in (config_in),
        .last      (ser_last)
    );

`ifdef MLBLOCK_CFG_READBACK_EN
    // Capture the bits falling out of the chain tail; after CHAIN_LEN shifts the first is the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_image <= '0;
            rb_valid <= 1'b0;
        end else begin
            if (config_en) rb_image <= {rb_image[CHAIN_LEN-2:0], config_out};
            rb_valid <= (state == SHIFT) && ser_last;
        end
    end
`else
    logic unused_config_out;
    assign unused_config_out = config_out;
`endif

endmodule

// File: tb/tb_mlblock_cfg_loader.sv
// Scoreboard bench for mlblock_cfg_loader: two instances (12-bit and 10-bit chains),
// each feeding a behavioural shift-register model of the downstream chain.
module tb_mlblock_cfg_loader;

    localparam int CLA = 12;
    localparam int CLB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instance A (CHAIN_LEN=12) ----------------
    logic           reset_a = 1'b1, start_a = 1'b0, valid_a = 1'b0;
    logic [7:0]     word_a = '0;
    logic           ready_a, en_a, cin_a, busy_a, done_a, cout_a;
    logic [CLA-1:0] chain_a = '0;
`ifdef MLBLOCK_CFG_READBACK_EN
    logic [CLA-1:0] rb_image_a;
    logic           rb_valid_a;
`endif

    mlblock_cfg_loader #(.CHAIN_LEN(CLA), .WORD_W(8)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .cfg_word(word_a), .cfg_word_valid(valid_a), .cfg_word_ready(ready_a),
        .config_en(en_a), .config_in(cin_a), .config_out(cout_a),
        .busy(busy_a), .done(done_a)
`ifdef MLBLOCK_CFG_READBACK_EN
        , .rb_image(rb_image_a), .rb_valid(rb_valid_a)
`endif
    );

    assign cout_a = chain_a[CLA-1];
    always @(posedge clk) if (en_a) chain_a <= {chain_a[CLA-2:0], cin_a};

    // ---------------- instance B (CHAIN_LEN=10, padded last word) ----------------
    logic           reset_b = 1'b1, start_b = 1'b0, valid_b = 1'b0;
    logic [7:0]     word_b = '0;
    logic           ready_b, en_b, cin_b, busy_b, done_b, cout_b;
    logic [CLB-1:0] chain_b = '0;
`ifdef MLBLOCK_CFG_READBACK_EN
    logic [CLB-1:0] rb_image_b;
    logic           rb_valid_b;
`endif

    mlblock_cfg_loader #(.CHAIN_LEN(CLB), .WORD_W(8)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .cfg_word(word_b), .cfg_word_valid(valid_b), .cfg_word_ready(ready_b),
        .config_en(en_b), .config_in(cin_b), .config_out(cout_b),
        .busy(busy_b), .done(done_b)
`ifdef MLBLOCK_CFG_READBACK_EN
        , .rb_image(rb_image_b), .rb_valid(rb_valid_b)
`endif
    );

    assign cout_b = chain_b[CLB-1];
    always @(posedge clk) if (en_b) chain_b <= {chain_b[CLB-2:0], cin_b};

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [15:0] img;
        bit          rb_chk;
        logic [15:0] rb;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    bit   bits_a[$];
    bit   bits_b[$];
    int   sc_a = 0, sc_b = 0;
    int   done_cnt_a = 0, done_cnt_b = 0;

    task automatic push_a(input logic [CLA-1:0] img, input bit rbc, input logic [CLA-1:0] rb);
        exp_a.push_back('{16'(img), rbc, 16'(rb)});
        for (int k = 0; k < CLA; k++) bits_a.push_back(img[CLA-1-k]);
    endtask

    task automatic push_b(input logic [CLB-1:0] img);
        exp_b.push_back('{16'(img), 1'b0, 16'h0});
        for (int k = 0; k < CLB; k++) bits_b.push_back(img[CLB-1-k]);
    endtask

    // Monitor A: every shift cycle pops an expected bit, every done pops an expected chain.
    always @(negedge clk) begin
        exp_t e;
        bit   b;
        if (en_a) begin
            if (bits_a.size() == 0) chk("spurious_shift_a", 32'(en_a), 32'd0);
            else begin
                b = bits_a.pop_front();
                chk("config_in_a", 32'(cin_a), 32'(b));
            end
            sc_a++;
        end
        if (done_a) begin
            done_cnt_a++;
            if (exp_a.size() == 0) chk("spurious_done_a", 32'(done_a), 32'd0);
            else begin
                e = exp_a.pop_front();
                chk("chain_a", 32'(chain_a), 32'(e.img));
                chk("shift_cnt_a", 32'(sc_a), CLA);
`ifdef MLBLOCK_CFG_READBACK_EN
                if (e.rb_chk) chk("rb_image_a", 32'(rb_image_a), 32'(e.rb));
`endif
            end
            sc_a = 0;
        end
`ifdef MLBLOCK_CFG_READBACK_EN
        if (done_a || rb_valid_a) chk("rb_valid_a", 32'(rb_valid_a), 32'(done_a));
`endif
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        bit   b;
        if (en_b) begin
            if (bits_b.size() == 0) chk("spurious_shift_b", 32'(en_b), 32'd0);
            else begin
                b = bits_b.pop_front();
                chk("config_in_b", 32'(cin_b), 32'(b));
            end
            sc_b++;
        end
        if (done_b) begin
            done_cnt_b++;
            if (exp_b.size() == 0) chk("spurious_done_b", 32'(done_b), 32'd0);
            else begin
                e = exp_b.pop_front();
                chk("chain_b", 32'(chain_b), 32'(e.img));
                chk("shift_cnt_b", 32'(sc_b), CLB);
            end
            sc_b = 0;
        end
`ifdef MLBLOCK_CFG_READBACK_EN
        if (done_b || rb_valid_b) chk("rb_valid_b", 32'(rb_valid_b), 32'(done_b));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] w0, input logic [7:0] w1, input int stall);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        valid_a = 1'b1;
        word_a  = w0;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("ready_in_stall", 32'(ready_a), 32'd1);
            chk("no_shift_in_stall", 32'(en_a), 32'd0);
            tick();
        end
        valid_a = 1'b1;
        word_a  = w1;
        tick();
        valid_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int max);
        int n = 0;
        while (busy_a && n < max) begin
            tick();
            n++;
        end
        chk("idle_timeout_a", 32'(busy_a), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_config_en", 32'(en_a), 32'd0);
        chk("rst_config_in", 32'(cin_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        // basic load 0xA5, 0x03 -> 0x3A5
        push_a(12'h3A5, 1'b0, 12'h0);
        load_a(8'hA5, 8'h03, 0);
        wait_idle_a(40);
        chk("done_count_basic", 32'(done_cnt_a), 32'd1);

        // stalled input between words
        push_a(12'h3A5, 1'b0, 12'h0);
        load_a(8'hA5, 8'h03, 5);
        wait_idle_a(40);
        chk("done_count_stall", 32'(done_cnt_a), 32'd2);

        // start pulsed during SHIFT and during DONE must be ignored
        push_a(12'h3A5, 1'b0, 12'h0);
        load_a(8'hA5, 8'h03, 0);
        repeat (3) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_a), 32'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("busy_after_done", 32'(busy_a), 32'd0);
        repeat (20) tick();
        chk("still_idle", 32'(busy_a), 32'd0);
        chk("done_count_ignored", 32'(done_cnt_a), 32'd3);

        // reset in the middle of SHIFT at k=6
        push_a(12'h5C3, 1'b0, 12'h0);
        load_a(8'hC3, 8'h05, 0);
        repeat (6) tick();
        chk("en_before_reset", 32'(en_a), 32'd1);
        reset_a = 1'b1;
        tick();
        chk("en_after_reset", 32'(en_a), 32'd0);
        chk("busy_after_reset", 32'(busy_a), 32'd0);
        chk("done_after_reset", 32'(done_a), 32'd0);
        reset_a = 1'b0;
        bits_a.delete();
        exp_a.delete();
        sc_a = 0;
        repeat (3) tick();
        chk("no_done_aborted", 32'(done_cnt_a), 32'd3);

        push_a(12'hFFF, 1'b0, 12'h0);
        load_a(8'hFF, 8'h0F, 0);
        wait_idle_a(40);
        chk("done_count_fff", 32'(done_cnt_a), 32'd4);

`ifdef MLBLOCK_CFG_READBACK_EN
        // readback returns the previous chain image
        push_a(12'h3A5, 1'b1, 12'hFFF);
        load_a(8'hA5, 8'h03, 0);
        wait_idle_a(40);
        push_a(12'h5C3, 1'b1, 12'h3A5);
        load_a(8'hC3, 8'h05, 0);
        wait_idle_a(40);
        chk("done_count_rb", 32'(done_cnt_a), 32'd6);
`endif

        // padding: CHAIN_LEN=10, words 0xFF 0xFF -> 0x3FF
        push_b(10'h3FF);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        valid_b = 1'b1;
        word_b  = 8'hFF;
        tick();
        chk("ready_b", 32'(ready_b), 32'd1);
        tick();
        valid_b = 1'b0;
        n = 0;
        while (busy_b && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout_b", 32'(busy_b), 32'd0);
        chk("done_count_b", 32'(done_cnt_b), 32'd1);

        chk("leftover_exp_a", 32'(exp_a.size()), 32'd0);
        chk("leftover_bits_b", 32'(bits_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mlblock_cfg_loader.md
Name: mlblock_cfg_loader

Overview:
- Writer end of the MLBlock serial configuration chain: config_en / config_in / config_out.
- Accepts a configuration image as parallel words over a valid/ready handshake and buffers the full image.
- Then shifts the image bit-serially into a chain of CHAIN_LEN flops formed by daisy-chained MLBlocks, and signals completion.
- Sits between the host or config controller and the first block's config_in; the last block's config_out returns to this block.

Parameters:
- CHAIN_LEN, 16: total configuration flops in the downstream chain (sum over all blocks).
- WORD_W, 8: width of the input configuration word.
- N_WORDS, derived = ceil(CHAIN_LEN/WORD_W): words per image (localparam, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- cfg_word  in  WORD_W  configuration word.
- cfg_word_valid  in  1  cfg_word is valid.
- cfg_word_ready  out  1  loader accepts a word this cycle.
- config_en  out  1  shift enable to the chain (registered).
- config_in  out  1  serial data to the chain head (registered).
- config_out  in  1  serial data returning from the chain tail.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the load completes.
- rb_image  out  CHAIN_LEN  previous chain contents (present only with the macro).
- rb_valid  out  1  rb_image valid pulse (present only with the macro).

Behaviour:
- Reset values: every output is 0; state is IDLE; word and bit counters are 0; the image register is 0.
- State machine, IDLE -> COLLECT -> SHIFT -> DONE -> IDLE.
- IDLE:
  - start=1 -> COLLECT next cycle.
  - start in any other state is ignored; it is not queued.
- COLLECT:
  - cfg_word_ready=1 for the whole state (combinational from state).
  - On valid&ready, the word is stored at image bits [wcnt*WORD_W +: WORD_W] and wcnt increments.
  - Bits at or above CHAIN_LEN in the last word are discarded.
  - The handshake that delivers word N_WORDS-1 moves the block to SHIFT next cycle.
  - The input stalls indefinitely while valid=0.
- SHIFT:
  - config_en=1 for exactly CHAIN_LEN consecutive cycles.
  - In the k-th cycle (k=0..CHAIN_LEN-1), config_in = image[CHAIN_LEN-1-k]; the MSB goes first.
  - After the last shift, chain flop p (p=0 nearest config_in) holds image[p].
  - config_en and config_in come from the same register stage, so they are always aligned.
  - config_en drops the cycle after the last bit.
- DONE:
  - done=1 for one cycle; busy=1 in this cycle.
  - Next state is IDLE. busy=0 from IDLE onward.
  - A start arriving in the DONE cycle is ignored.
- Reset mid-operation:
  - From the next edge: config_en=0, state IDLE, no done pulse.
  - The chain contents are then undefined.
  - A partially collected image is discarded.
- Back-to-back loads: the earliest accepted start is in the first IDLE cycle after DONE.
- Latency from start to done: 1 + (COLLECT cycles, at least N_WORDS) + CHAIN_LEN + 1.
- config_out is ignored unless the macro is defined.

Optional Feature:
- Macro: MLBLOCK_CFG_READBACK_EN.
- When defined:
  - On each clock edge with config_en=1, config_out is sampled into rb_image[CHAIN_LEN-1-k].
  - This captures the chain's previous image, MSB first.
  - rb_valid pulses together with done; rb_image holds until the next load.
  - rb_image resets to 0.
- When undefined: rb_image and rb_valid ports and their logic do not exist, and config_out is left unused.

Decomposition:
- Shared package mlblock_cfg_pkg:
  - state enum cfg_state_t {IDLE, COLLECT, SHIFT, DONE};
  - function clog2_ceil_div for N_WORDS;
  - counter width constants.
- One natural sub-module, mlblock_cfg_serializer: a PISO (parallel-in, serial-out) register of CHAIN_LEN bits with a bit counter, producing config_en/config_in and a last-bit flag.
- The FSM and the word collector stay in the top module.

Test Plan:
- Basic load, CHAIN_LEN=12, WORD_W=8, N_WORDS=2: start, then words 0xA5 and 0x03 → image 0x3A5. config_en is high for 12 cycles with config_in = 0,0,1,1,1,0,1,0,0,1,0,1. The behavioural 12-bit chain model holds 0x3A5. done pulses once.
- Stalled input: valid low for 5 cycles between the words → ready stays 1, no shifting before the second word, final chain still 0x3A5.
- Ignored start: start pulsed during SHIFT and during DONE → no second load, busy falls after the single done.
- Reset mid-SHIFT at k=6 → config_en=0 next cycle, busy=0, no done. A following full load of 0xFFF gives chain 0xFFF.
- Readback (macro on): load 0x3A5, then load 0x5C3 → on the second done, rb_valid=1 and rb_image=0x3A5, and the chain holds 0x5C3.
- Padding, CHAIN_LEN=10: words 0xFF and 0xFF → chain 0x3FF. Exactly 10 shift cycles.
